// File: rtl/dcache_resp_assembler.sv
// dcache_resp_assembler
//   Return path of the dcache request queue. Each queue entry's 512-bit
//   request goes out as two 256-bit bus transactions. This block collects
//   both 256-bit responses per entry, rebuilds the 512-bit line and hands
//   completed lines to the load path one at a time. It also tells the
//   request queue when an entry can be retired.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   alloc_*           entry open: index, load/store flag, vadr, ROB index
//   alloc_ok          the alloc_ndx entry is IDLE (combinational)
//   resp_*            bus response: entry tag, half select, error, data
//   line_*            registered assembled-line output, valid/ready handshake
//   free_v/free_ndx   one-cycle retire pulse, the cycle after line handoff
//   stray             one-cycle pulse for a response that was not accepted
module dcache_resp_assembler #(
    parameter int NENT   = 4,
    parameter int ADR_W  = 32,
    parameter int RNDX_W = 6,
    localparam int TW    = $clog2(NENT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_v,
    input  logic [TW-1:0]     alloc_ndx,
    input  logic              alloc_is_load,
    input  logic [ADR_W-1:0]  alloc_vadr,
    input  logic [RNDX_W-1:0] alloc_rndx,
    output logic              alloc_ok,
    input  logic              resp_v,
    input  logic [TW-1:0]     resp_tid,
    input  logic              resp_half,
    input  logic              resp_err,
    input  logic [255:0]      resp_dat,
    output logic              line_v,
    input  logic              line_rdy,
    output logic [TW-1:0]     line_ndx,
    output logic [ADR_W-1:0]  line_vadr,
    output logic [RNDX_W-1:0] line_rndx,
    output logic              line_is_load,
    output logic              line_err,
    output logic [511:0]      line_dat,
    output logic              free_v,
    output logic [TW-1:0]     free_ndx,
    output logic              stray
);

    typedef enum logic [1:0] {IDLE, WAIT, READY, OUT} ent_state_t;

    ent_state_t        state     [NENT];
    ent_state_t        state_nxt [NENT];
    logic [1:0]        loaded    [NENT];
    logic [NENT-1:0]   err;
    logic [NENT-1:0]   is_load;
    logic [ADR_W-1:0]  vadr      [NENT];
    logic [RNDX_W-1:0] rndx      [NENT];
    logic [511:0]      data      [NENT];

    logic              alloc_take;
    logic              resp_ok;
    logic [1:0]        half_mask;
    logic              out_free;
    logic              line_fire;
    logic              found;
    logic              gnt_v;
    logic [TW-1:0]     gnt_ndx;
    logic [TW-1:0]     last_gnt;

    assign alloc_ok   = (state[alloc_ndx] == IDLE);
    assign alloc_take = alloc_v && alloc_ok;
    assign half_mask  = resp_half ? 2'b10 : 2'b01;
    // Only a WAIT entry with that half still missing takes a response.
    assign resp_ok    = resp_v && (state[resp_tid] == WAIT) &&
                        ((loaded[resp_tid] & half_mask) == 2'b00);
    assign line_fire  = line_v && line_rdy;
    // Output register may reload on the handoff edge itself (no bubble).
    assign out_free   = !line_v || line_rdy;

    // Round-robin: search starts at the entry after the last grant.
    always_comb begin
        found   = 1'b0;
        gnt_ndx = '0;
        for (int unsigned i = 1; i <= int'(NENT); i++) begin
            int unsigned idx;
            idx = (int'(last_gnt) + i) % NENT;
            if (!found && state[idx] == READY) begin
                found   = 1'b1;
                gnt_ndx = TW'(idx);
            end
        end
        gnt_v = found && out_free;
    end

    always_comb begin
        for (int unsigned e = 0; e < NENT; e++) begin
            state_nxt[e] = state[e];
            case (state[e])
                IDLE:  if (alloc_take && alloc_ndx == TW'(e))
                           state_nxt[e] = WAIT;
                WAIT:  if (resp_ok && resp_tid == TW'(e) &&
                           (loaded[e] | half_mask) == 2'b11)
                           state_nxt[e] = READY;
                READY: if (gnt_v && gnt_ndx == TW'(e))
                           state_nxt[e] = OUT;
                OUT:   if (line_fire && line_ndx == TW'(e))
                           state_nxt[e] = IDLE;
                default: state_nxt[e] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned e = 0; e < NENT; e++) state[e] <= IDLE;
        end else begin
            for (int unsigned e = 0; e < NENT; e++) state[e] <= state_nxt[e];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= '0;
            is_load <= '0;
            for (int unsigned e = 0; e < NENT; e++) begin
                loaded[e] <= 2'b00;
                vadr[e]   <= '0;
                rndx[e]   <= '0;
                data[e]   <= '0;
            end
        end else begin
            for (int unsigned e = 0; e < NENT; e++) begin
                if (alloc_take && alloc_ndx == TW'(e)) begin
                    loaded[e]  <= 2'b00;
                    err[e]     <= 1'b0;
                    is_load[e] <= alloc_is_load;
                    vadr[e]    <= alloc_vadr;
                    rndx[e]    <= alloc_rndx;
                    data[e]    <= '0;
                end else if (resp_ok && resp_tid == TW'(e)) begin
                    loaded[e] <= loaded[e] | half_mask;
                    err[e]    <= err[e] | resp_err;
                    if (is_load[e])
                        data[e][(resp_half ? 256 : 0) +: 256] <= resp_dat;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_v       <= 1'b0;
            line_ndx     <= '0;
            line_vadr    <= '0;
            line_rndx    <= '0;
            line_is_load <= 1'b0;
            line_err     <= 1'b0;
            line_dat     <= '0;
            free_v       <= 1'b0;
            free_ndx     <= '0;
            stray        <= 1'b0;
            last_gnt     <= TW'(NENT - 1);
        end else begin
            if (out_free) line_v <= gnt_v;
            if (gnt_v) begin
                line_ndx     <= gnt_ndx;
                line_vadr    <= vadr[gnt_ndx];
                line_rndx    <= rndx[gnt_ndx];
                line_is_load <= is_load[gnt_ndx];
                line_err     <= err[gnt_ndx];
                line_dat     <= data[gnt_ndx];
                last_gnt     <= gnt_ndx;
            end
            free_v <= line_fire;
            if (line_fire) free_ndx <= line_ndx;
            stray <= resp_v && !resp_ok;
        end
    end

endmodule

// File: tb/tb_dcache_resp_assembler.sv
// tb_dcache_resp_assembler
//   Directed bench for dcache_resp_assembler (NENT=4, ADR_W=32, RNDX_W=6).
//   Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_dcache_resp_assembler;

    logic         clk;
    logic         rst;
    logic         alloc_v;
    logic [1:0]   alloc_ndx;
    logic         alloc_is_load;
    logic [31:0]  alloc_vadr;
    logic [5:0]   alloc_rndx;
    logic         alloc_ok;
    logic         resp_v;
    logic [1:0]   resp_tid;
    logic         resp_half;
    logic         resp_err;
    logic [255:0] resp_dat;
    logic         line_v;
    logic         line_rdy;
    logic [1:0]   line_ndx;
    logic [31:0]  line_vadr;
    logic [5:0]   line_rndx;
    logic         line_is_load;
    logic         line_err;
    logic [511:0] line_dat;
    logic         free_v;
    logic [1:0]   free_ndx;
    logic         stray;

    int checks = 0;
    int errors = 0;

    dcache_resp_assembler #(.NENT(4), .ADR_W(32), .RNDX_W(6)) dut (
        .clk(clk), .rst(rst),
        .alloc_v(alloc_v), .alloc_ndx(alloc_ndx), .alloc_is_load(alloc_is_load),
        .alloc_vadr(alloc_vadr), .alloc_rndx(alloc_rndx), .alloc_ok(alloc_ok),
        .resp_v(resp_v), .resp_tid(resp_tid), .resp_half(resp_half),
        .resp_err(resp_err), .resp_dat(resp_dat),
        .line_v(line_v), .line_rdy(line_rdy), .line_ndx(line_ndx),
        .line_vadr(line_vadr), .line_rndx(line_rndx), .line_is_load(line_is_load),
        .line_err(line_err), .line_dat(line_dat),
        .free_v(free_v), .free_ndx(free_ndx), .stray(stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $error("FAIL timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [255:0] pat(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [1:0] n, input logic ld, input logic [31:0] va,
                            input logic [5:0] rn);
        alloc_v = 1'b1; alloc_ndx = n; alloc_is_load = ld; alloc_vadr = va; alloc_rndx = rn;
        tick();
        alloc_v = 1'b0;
    endtask

    task automatic do_resp(input logic [1:0] n, input logic h, input logic e,
                           input logic [255:0] d);
        resp_v = 1'b1; resp_tid = n; resp_half = h; resp_err = e; resp_dat = d;
        tick();
        resp_v = 1'b0; resp_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alloc_v = 1'b0; alloc_ndx = '0; alloc_is_load = 1'b0; alloc_vadr = '0; alloc_rndx = '0;
        resp_v = 1'b0; resp_tid = '0; resp_half = 1'b0; resp_err = 1'b0; resp_dat = '0;
        line_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_line_v", line_v, 0);
        chk("rst_line_dat", line_dat, 0);
        chk("rst_line_ndx", line_ndx, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_free_v", free_v, 0);
        chk("rst_stray", stray, 0);
        chk("rst_alloc_ok", alloc_ok, 1);

        // Single load line, halves in order
        alloc_ndx = 2'd1;
        #1 chk("t1_alloc_ok_idle", alloc_ok, 1);
        do_alloc(2'd1, 1'b1, 32'h0000_1000, 6'd5);
        chk("t1_alloc_ok_busy", alloc_ok, 0);
        do_resp(2'd1, 1'b0, 1'b0, pat(32'hAAAA_0001));
        do_resp(2'd1, 1'b1, 1'b0, pat(32'hBBBB_0002));
        chk("t1_line_v_early", line_v, 0);
        tick();
        chk("t1_line_v", line_v, 1);
        chk("t1_line_dat", line_dat, {pat(32'hBBBB_0002), pat(32'hAAAA_0001)});
        chk("t1_line_rndx", line_rndx, 5);
        chk("t1_line_ndx", line_ndx, 1);
        chk("t1_line_vadr", line_vadr, 32'h0000_1000);
        chk("t1_line_is_load", line_is_load, 1);
        chk("t1_line_err", line_err, 0);
        chk("t1_free_v_before", free_v, 0);
        line_rdy = 1'b1;
        tick();
        line_rdy = 1'b0;
        chk("t1_free_v", free_v, 1);
        chk("t1_free_ndx", free_ndx, 1);
        chk("t1_line_v_drop", line_v, 0);
        alloc_ndx = 2'd1;
        tick();
        chk("t1_free_v_pulse", free_v, 0);
        chk("t1_alloc_ok_freed", alloc_ok, 1);

        // Interleaved halves, entry 2 completes first
        do_alloc(2'd0, 1'b1, 32'h0000_2000, 6'd7);
        do_alloc(2'd2, 1'b1, 32'h0000_3000, 6'd9);
        do_resp(2'd0, 1'b1, 1'b0, pat(32'hCCCC_0003));
        do_resp(2'd2, 1'b1, 1'b0, pat(32'hEEEE_0005));
        do_resp(2'd2, 1'b0, 1'b0, pat(32'hDDDD_0004));
        do_resp(2'd0, 1'b0, 1'b0, pat(32'h6666_0006));
        chk("t2_first_v", line_v, 1);
        chk("t2_first_ndx", line_ndx, 2);
        chk("t2_first_dat", line_dat, {pat(32'hEEEE_0005), pat(32'hDDDD_0004)});
        chk("t2_first_rndx", line_rndx, 9);
        line_rdy = 1'b1;
        tick();
        chk("t2_second_v", line_v, 1);
        chk("t2_second_ndx", line_ndx, 0);
        chk("t2_second_dat", line_dat, {pat(32'hCCCC_0003), pat(32'h6666_0006)});
        chk("t2_free_ndx2", free_ndx, 2);
        chk("t2_free_v2", free_v, 1);
        tick();
        line_rdy = 1'b0;
        chk("t2_line_v_end", line_v, 0);
        chk("t2_free_ndx0", free_ndx, 0);

        // Store with error on half 0
        do_alloc(2'd3, 1'b0, 32'h0000_4000, 6'd3);
        do_resp(2'd3, 1'b0, 1'b1, pat(32'h1234_5678));
        do_resp(2'd3, 1'b1, 1'b0, pat(32'h9ABC_DEF0));
        tick();
        chk("t4_line_v", line_v, 1);
        chk("t4_line_ndx", line_ndx, 3);
        chk("t4_is_load", line_is_load, 0);
        chk("t4_line_dat", line_dat, 0);
        chk("t4_line_err", line_err, 1);
        chk("t4_line_rndx", line_rndx, 3);
        line_rdy = 1'b1;
        tick();
        line_rdy = 1'b0;
        chk("t4_free_ndx", free_ndx, 3);

        // Round-robin with held output
        do_alloc(2'd0, 1'b1, 32'h0000_5000, 6'd10);
        do_alloc(2'd1, 1'b1, 32'h0000_5040, 6'd11);
        do_alloc(2'd3, 1'b1, 32'h0000_50C0, 6'd12);
        do_resp(2'd0, 1'b0, 1'b0, pat(32'h0000_0B00));
        do_resp(2'd1, 1'b0, 1'b0, pat(32'h0000_0B10));
        do_resp(2'd3, 1'b0, 1'b0, pat(32'h0000_0B30));
        do_resp(2'd0, 1'b1, 1'b0, pat(32'h0000_0B01));
        do_resp(2'd1, 1'b1, 1'b0, pat(32'h0000_0B11));
        do_resp(2'd3, 1'b1, 1'b0, pat(32'h0000_0B31));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_v", line_v, 1);
            chk("t3_hold_ndx", line_ndx, 0);
            chk("t3_hold_rndx", line_rndx, 10);
            chk("t3_hold_dat", line_dat, {pat(32'h0000_0B01), pat(32'h0000_0B00)});
        end
        line_rdy = 1'b1;
        tick();
        chk("t3_rr1_ndx", line_ndx, 1);
        chk("t3_rr1_dat", line_dat, {pat(32'h0000_0B11), pat(32'h0000_0B10)});
        chk("t3_rr1_free", free_ndx, 0);
        tick();
        chk("t3_rr2_ndx", line_ndx, 3);
        chk("t3_rr2_v", line_v, 1);
        chk("t3_rr2_dat", line_dat, {pat(32'h0000_0B31), pat(32'h0000_0B30)});
        chk("t3_rr2_free", free_ndx, 1);
        tick();
        line_rdy = 1'b0;
        chk("t3_end_v", line_v, 0);
        chk("t3_end_free", free_ndx, 3);

        // Stray responses
        do_resp(2'd2, 1'b0, 1'b0, pat(32'hDEAD_0000));
        chk("t5_stray_idle", stray, 1);
        tick();
        chk("t5_stray_clear", stray, 0);
        do_alloc(2'd0, 1'b1, 32'h0000_6000, 6'd20);
        do_resp(2'd0, 1'b0, 1'b0, pat(32'h7777_0007));
        chk("t5_accept_no_stray", stray, 0);
        do_resp(2'd0, 1'b0, 1'b0, pat(32'hBAD0_BAD0));
        chk("t5_stray_dup", stray, 1);
        tick();
        chk("t5_stray_clear2", stray, 0);
        chk("t5_no_line", line_v, 0);
        do_resp(2'd0, 1'b1, 1'b0, pat(32'h8888_0008));
        tick();
        chk("t5_line_v", line_v, 1);
        chk("t5_line_dat", line_dat, {pat(32'h8888_0008), pat(32'h7777_0007)});
        // Same-cycle alloc and response to an IDLE entry
        alloc_v = 1'b1; alloc_ndx = 2'd2; alloc_is_load = 1'b1;
        alloc_vadr = 32'h0000_7000; alloc_rndx = 6'd21;
        resp_v = 1'b1; resp_tid = 2'd2; resp_half = 1'b0; resp_dat = pat(32'h5555_0005);
        tick();
        alloc_v = 1'b0; resp_v = 1'b0;
        chk("t5_stray_alloc_same", stray, 1);
        chk("t5_alloc_taken", alloc_ok, 0);

        // Reset mid-cycle with entry 1 in WAIT and a line pending
        do_alloc(2'd1, 1'b1, 32'h0000_8000, 6'd30);
        do_resp(2'd1, 1'b0, 1'b0, pat(32'h4444_0004));
        chk("t6_line_v_pre", line_v, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_line_v_rst", line_v, 0);
        chk("t6_line_dat_rst", line_dat, 0);
        for (int n = 0; n < 4; n++) begin
            alloc_ndx = 2'(n);
            #1 chk("t6_alloc_ok", alloc_ok, 1);
        end
        tick();
        rst = 1'b0;
        line_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_free", free_v, 0);
            chk("t6_no_line", line_v, 0);
        end
        line_rdy = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
